updown_mod_counter: RTL and testbench

Parametrised up/down modulo-N counter with synchronous parallel load, count enable, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Successor to the fixed 8-bit toggle counter: same board role (switch/key-driven count shown on seven-segment displays), generalised in width, modulus and direction. Drives one active-low seven-segment digit per nibble of the count.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/hex7seg.sv | 32 +++
 rtl/updown_mod_counter.sv | 78 +++++++
 tb/tb_updown_mod_counter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared seven-segment constants for the up/down modulo counter
package counter_pkg;

    localparam int SEG_W = 7;

    // Active-low segment patterns, bit order g..a
    localparam logic [SEG_W-1:0] SEG_0     = 7'b100_0000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b111_1001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b010_0100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b011_0000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b001_1001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b001_0010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b000_0010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b111_1000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b000_0000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b001_0000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b000_1000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b000_0011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b100_0110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b010_0001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b000_0110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b000_1110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7f;

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational nibble to active-low seven-segment decoder
module hex7seg
    import counter_pkg::*;
(
    input  logic [3:0]       i_nib,
    output logic [SEG_W-1:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo-N counter with load, wrap/saturate, tc, sticky ovf
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 256
) (
    input  logic                     clk,
    input  logic                     clear_b,
    input  logic                     en,
    input  logic                     up,
    input  logic                     sat,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_val,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         count,
    output logic                     tc,
    output logic                     ovf,
    output logic [SEG_W*(WIDTH/4)-1:0] hex
);

    localparam int DIGITS = WIDTH / 4;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_at_bound;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_load;

    // Boundary is detected against MAX_VAL/0 before stepping, so the
    // increment never relies on 2**WIDTH rollover.
    always_comb begin
        w_at_bound = up ? (r_count == MAX_VAL) : (r_count == '0);
        w_step     = up ? (r_count + 1'b1) : (r_count - 1'b1);
        w_wrap     = up ? '0 : MAX_VAL;
        w_load     = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            r_count <= w_load;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (en && w_at_bound) begin
            r_count <= sat ? r_count : w_wrap;
            r_tc    <= 1'b1;
            r_ovf   <= 1'b1;
        end else begin
            if (en) begin
                r_count <= w_step;
            end
            r_tc <= 1'b0;
            if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        hex7seg u_hex7seg (
            .i_nib (r_count[4*k +: 4]),
            .o_seg (hex[SEG_W*k +: SEG_W])
        );
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - model-checked bench for two counter configurations
module tb_updown_mod_counter;

    typedef struct {
        longint cnt;
        bit     tc;
        bit     ovf;
    } st_t;

    logic [6:0] seg_tab [16] = '{
        7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
        7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
        7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
        7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
    };

    int total = 0;
    int bad   = 0;
    bit mon_on = 0;

    logic clk = 0;
    logic clear_b = 1;
    always #5 clk = ~clk;

    // instance a: WIDTH=8 MODULUS=256, instance b: WIDTH=4 MODULUS=10
    logic       a_en = 0, a_up = 0, a_sat = 0, a_load = 0, a_clr = 0;
    logic [7:0] a_lv = 0;
    logic [7:0] a_count;
    logic       a_tc, a_ovf;
    logic [13:0] a_hex;

    logic       b_en = 0, b_up = 0, b_sat = 0, b_load = 0, b_clr = 0;
    logic [3:0] b_lv = 0;
    logic [3:0] b_count;
    logic       b_tc, b_ovf;
    logic [6:0] b_hex;

    updown_mod_counter #(.WIDTH(8), .MODULUS(256)) dut_a (
        .clk(clk), .clear_b(clear_b), .en(a_en), .up(a_up), .sat(a_sat),
        .load(a_load), .load_val(a_lv), .clr_ovf(a_clr),
        .count(a_count), .tc(a_tc), .ovf(a_ovf), .hex(a_hex)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk(clk), .clear_b(clear_b), .en(b_en), .up(b_up), .sat(b_sat),
        .load(b_load), .load_val(b_lv), .clr_ovf(b_clr),
        .count(b_count), .tc(b_tc), .ovf(b_ovf), .hex(b_hex)
    );

    function automatic st_t step(st_t s, longint m, bit ld, longint lv,
                                 bit e, bit u, bit sa, bit clr);
        st_t    n;
        longint t;
        n    = s;
        n.tc = 0;
        if (ld) begin
            n.cnt = (lv < m) ? lv : m - 1;
            n.ovf = 0;
        end else if (e) begin
            t = u ? s.cnt + 1 : s.cnt - 1;
            if (t < 0 || t >= m) begin
                n.tc  = 1;
                n.ovf = 1;
                n.cnt = sa ? s.cnt : ((t % m) + m) % m;
            end else begin
                n.cnt = t;
                if (clr) n.ovf = 0;
            end
        end else if (clr) begin
            n.ovf = 0;
        end
        return n;
    endfunction

    function automatic logic [63:0] hex_of(longint c, int digits);
        logic [63:0] h;
        h = '0;
        for (int k = 0; k < digits; k++)
            h[7*k +: 7] = seg_tab[(c >> (4*k)) & 15];
        return h;
    endfunction

    st_t ma = '{0, 0, 0};
    st_t mb = '{0, 0, 0};

    always @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            ma <= '{0, 0, 0};
            mb <= '{0, 0, 0};
        end else begin
            ma <= step(ma, 256, a_load, longint'(a_lv), a_en, a_up, a_sat, a_clr);
            mb <= step(mb, 10,  b_load, longint'(b_lv), b_en, b_up, b_sat, b_clr);
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("a_count", 64'(a_count), 64'(ma.cnt));
            chk("a_tc",    64'(a_tc),    64'(ma.tc));
            chk("a_ovf",   64'(a_ovf),   64'(ma.ovf));
            chk("a_hex",   64'(a_hex),   hex_of(ma.cnt, 2));
            chk("b_count", 64'(b_count), 64'(mb.cnt));
            chk("b_tc",    64'(b_tc),    64'(mb.tc));
            chk("b_ovf",   64'(b_ovf),   64'(mb.ovf));
            chk("b_hex",   64'(b_hex),   hex_of(mb.cnt, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_a(string nm, logic [7:0] c, bit t, bit o);
        chk({nm, "_count"}, 64'(a_count), 64'(c));
        chk({nm, "_tc"},    64'(a_tc),    64'(t));
        chk({nm, "_ovf"},   64'(a_ovf),   64'(o));
    endtask

    task automatic lit_b(string nm, logic [3:0] c, bit t, bit o);
        chk({nm, "_count"}, 64'(b_count), 64'(c));
        chk({nm, "_tc"},    64'(b_tc),    64'(t));
        chk({nm, "_ovf"},   64'(b_ovf),   64'(o));
    endtask

    initial begin
        #1 clear_b = 0;
        #2 mon_on = 1;
        tick(); tick();
        lit_a("rst_a", 8'h00, 0, 0);
        lit_b("rst_b", 4'h0, 0, 0);
        clear_b = 1;

        // wrap up on the 8-bit instance
        a_load = 1; a_lv = 8'hFE; tick();
        lit_a("ld_fe", 8'hFE, 0, 0);
        a_load = 0; a_en = 1; a_up = 1; a_sat = 0; tick();
        lit_a("up_ff", 8'hFF, 0, 0);
        chk("hex_ff", 64'(a_hex), 64'(14'b0001110_0001110));
        tick();
        lit_a("wrap_00", 8'h00, 1, 1);
        chk("hex_00", 64'(a_hex), 64'(14'b1000000_1000000));
        tick();
        lit_a("up_01", 8'h01, 0, 1);

        // down to 0xFF, then load beats enable
        a_up = 0; tick(); tick();
        lit_a("dn_ff", 8'hFF, 1, 1);
        a_load = 1; a_lv = 8'h42; a_up = 1; tick();
        lit_a("prio_ld", 8'h42, 0, 0);
        a_lv = 8'hFF; a_en = 0; tick();
        a_load = 0; a_en = 1; a_clr = 1; tick();
        lit_a("clr_vs_bnd", 8'h00, 1, 1);
        a_en = 0; tick();
        lit_a("clr_ovf", 8'h00, 0, 0);
        a_clr = 0;

        // hold with up toggling
        for (int i = 0; i < 5; i++) begin
            a_up = ~a_up; b_up = ~b_up; tick();
        end
        lit_a("hold_a", 8'h00, 0, 0);

        // decade counter down from 0
        b_en = 1; b_up = 0; b_sat = 0; tick();
        lit_b("dec_9", 4'h9, 1, 1);
        tick();
        lit_b("dec_8", 4'h8, 0, 1);
        b_en = 0; b_load = 1; b_lv = 4'd12; tick();
        lit_b("clamp", 4'h9, 0, 0);
        chk("hex_9", 64'(b_hex), 64'(7'b001_0000));
        b_load = 0;

        // saturate at 9
        b_en = 1; b_up = 1; b_sat = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit_b("sat_9", 4'h9, 1, 1);
        end
        b_en = 0; b_clr = 1; tick();
        lit_b("sat_clr", 4'h9, 0, 0);
        b_clr = 0;

        // mixed direction/mode sweep checked by the model
        for (int i = 0; i < 24; i++) begin
            b_en = (i % 5) != 4; b_up = (i / 3) % 2; b_sat = (i / 7) % 2;
            b_clr = (i % 6) == 0;
            a_en = 1; a_up = (i / 4) % 2; a_sat = (i / 9) % 2;
            tick();
        end
        a_en = 0; b_en = 0; b_clr = 0;

        // asynchronous reset mid-cycle
        a_load = 1; a_lv = 8'h37; tick();
        a_load = 0;
        lit_a("ld_37", 8'h37, 0, 0);
        #2 clear_b = 0;
        #1;
        lit_a("async_rst", 8'h00, 0, 0);
        chk("async_hex", 64'(a_hex), 64'(14'b1000000_1000000));
        tick();
        clear_b = 1;
        a_en = 1; a_up = 1; tick();
        lit_a("post_rst", 8'h01, 0, 0);
        a_en = 0;
        tick();

        mon_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
